// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one line-wide main memory between the instruction and data caches.
// Round-robin on ties; each access holds GNT for at least two cycles, then a one-cycle DONE.
module mem_port_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              INS_READ,
   input  logic [ADDR_W-1:0] INS_ADDRESS,
   output logic [LINE_W-1:0] INS_READ_DATA,
   output logic              INS_BUSY_WAIT,
   input  logic              DATA_READ,
   input  logic              DATA_WRITE,
   input  logic [ADDR_W-1:0] DATA_ADDRESS,
   input  logic [LINE_W-1:0] DATA_WRITE_DATA,
   output logic [LINE_W-1:0] DATA_READ_DATA,
   output logic              DATA_BUSY_WAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDRESS,
   output logic [LINE_W-1:0] MEM_WRITE_DATA,
   input  logic [LINE_W-1:0] MEM_READ_DATA,
   input  logic              MEM_BUSY_WAIT
);

   typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;

   state_t            state;
   logic              last;       // 1: D side was granted last
   logic              started;
   logic              op_write;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] ird_q;
   logic [LINE_W-1:0] drd_q;

   logic i_pend;
   logic d_pend;
   logic pick_d;

   assign i_pend = INS_READ;
   assign d_pend = DATA_READ | DATA_WRITE;
   assign pick_d = d_pend && (!i_pend || !last);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         last        <= 1'b1;
         started     <= 1'b0;
         op_write    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ird_q       <= '0;
         drd_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_pend || d_pend) begin
                  started <= 1'b0;
                  last    <= pick_d;
                  if (pick_d) begin
                     state       <= GNT_D;
                     addr_q      <= DATA_ADDRESS;
                     wdata_q     <= DATA_WRITE_DATA;
                     op_write    <= DATA_WRITE;
                     mem_read_q  <= !DATA_WRITE;
                     mem_write_q <= DATA_WRITE;
                  end else begin
                     state       <= GNT_I;
                     addr_q      <= INS_ADDRESS;
                     op_write    <= 1'b0;
                     mem_read_q  <= 1'b1;
                     mem_write_q <= 1'b0;
                  end
               end
            end
            GNT_I, GNT_D: begin
               started <= 1'b1;
               // The first GNT cycle never completes, even if memory is not busy yet.
               if (started && !MEM_BUSY_WAIT) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (op_write) begin
                     state <= DONE_D;
                  end else if (state == GNT_I) begin
                     ird_q <= MEM_READ_DATA;
                     state <= DONE_I;
                  end else begin
                     drd_q <= MEM_READ_DATA;
                     state <= DONE_D;
                  end
               end
            end
            DONE_I, DONE_D: state <= IDLE;
            default:        state <= IDLE;
         endcase
      end
   end

   assign MEM_READ       = mem_read_q;
   assign MEM_WRITE      = mem_write_q;
   assign MEM_ADDRESS    = addr_q;
   assign MEM_WRITE_DATA = wdata_q;
   assign INS_READ_DATA  = ird_q;
   assign DATA_READ_DATA = drd_q;
   assign INS_BUSY_WAIT  = i_pend && (state != DONE_I);
   assign DATA_BUSY_WAIT = d_pend && (state != DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW = 28;
   localparam int LW = 128;

   logic          CLK;
   logic          RESET;
   logic          INS_READ;
   logic [AW-1:0] INS_ADDRESS;
   logic [LW-1:0] INS_READ_DATA;
   logic          INS_BUSY_WAIT;
   logic          DATA_READ;
   logic          DATA_WRITE;
   logic [AW-1:0] DATA_ADDRESS;
   logic [LW-1:0] DATA_WRITE_DATA;
   logic [LW-1:0] DATA_READ_DATA;
   logic          DATA_BUSY_WAIT;
   logic          MEM_READ;
   logic          MEM_WRITE;
   logic [AW-1:0] MEM_ADDRESS;
   logic [LW-1:0] MEM_WRITE_DATA;
   logic [LW-1:0] MEM_READ_DATA;
   logic          MEM_BUSY_WAIT;

   mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .CLK(CLK), .RESET(RESET),
      .INS_READ(INS_READ), .INS_ADDRESS(INS_ADDRESS),
      .INS_READ_DATA(INS_READ_DATA), .INS_BUSY_WAIT(INS_BUSY_WAIT),
      .DATA_READ(DATA_READ), .DATA_WRITE(DATA_WRITE), .DATA_ADDRESS(DATA_ADDRESS),
      .DATA_WRITE_DATA(DATA_WRITE_DATA), .DATA_READ_DATA(DATA_READ_DATA),
      .DATA_BUSY_WAIT(DATA_BUSY_WAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA),
      .MEM_BUSY_WAIT(MEM_BUSY_WAIT)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;
   bit idle_busy_rand = 1'b0;
   int mem_n = 0;
   int mem_age = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Memory responder: busy for mem_n cycles starting the cycle after it first sees a request.
   always @(posedge CLK) begin
      #1;
      if (MEM_READ || MEM_WRITE) begin
         mem_age++;
         MEM_BUSY_WAIT = (mem_age >= 2) && (mem_age <= mem_n + 1);
      end else begin
         mem_age = 0;
         MEM_BUSY_WAIT = idle_busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Reference model: one outstanding transaction, owner side 1=I 2=D, done side for one cycle.
   int            m_owner, m_done, m_last, m_cyc;
   bit            m_write;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata, m_ird, m_drd;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_owner = 0; m_done = 0; m_last = 2; m_cyc = 0; m_write = 1'b0;
         m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
      end else if (m_owner != 0) begin
         if (m_cyc >= 1 && !MEM_BUSY_WAIT) begin
            if (!m_write) begin
               if (m_owner == 1) m_ird = MEM_READ_DATA;
               else m_drd = MEM_READ_DATA;
            end
            m_done  = m_write ? 2 : m_owner;
            m_owner = 0;
         end else begin
            m_cyc++;
         end
      end else if (m_done != 0) begin
         m_done = 0;
      end else begin
         bit ip, dp;
         ip = INS_READ;
         dp = DATA_READ || DATA_WRITE;
         if (ip || dp) begin
            m_owner = (ip && dp) ? (3 - m_last) : (ip ? 1 : 2);
            m_last  = m_owner;
            m_cyc   = 0;
            if (m_owner == 1) begin
               m_addr  = INS_ADDRESS;
               m_write = 1'b0;
            end else begin
               m_addr  = DATA_ADDRESS;
               m_write = DATA_WRITE;
               m_wdata = DATA_WRITE_DATA;
            end
         end
      end
   end

   // scoreboard compare every cycle
   always @(negedge CLK) begin
      if (check_en) begin
         chk("mem_read",   LW'(MEM_READ),  LW'(m_owner != 0 && !m_write));
         chk("mem_write",  LW'(MEM_WRITE), LW'(m_owner != 0 && m_write));
         chk("mem_addr",   LW'(MEM_ADDRESS), LW'(m_addr));
         chk("mem_wdata",  MEM_WRITE_DATA, m_wdata);
         chk("ins_rdata",  INS_READ_DATA, m_ird);
         chk("data_rdata", DATA_READ_DATA, m_drd);
         chk("ins_busy",   LW'(INS_BUSY_WAIT), LW'(INS_READ && m_done != 1));
         chk("data_busy",  LW'(DATA_BUSY_WAIT), LW'((DATA_READ || DATA_WRITE) && m_done != 2));
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drop_all();
      INS_READ = 1'b0; DATA_READ = 1'b0; DATA_WRITE = 1'b0;
   endtask

   task automatic settle();
      drop_all();
      repeat (14) tick();
   endtask

   task automatic do_reset();
      drop_all();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();
   endtask

   // Waits (bounded) for the side's BUSY_WAIT to go low, counting edges from the call.
   task automatic serve(input int side, output int lat, output bit saw_rd, output bit saw_wr,
                        output logic [AW-1:0] addr_at, output logic [LW-1:0] wd_at);
      logic busy;
      lat = 0; saw_rd = 1'b0; saw_wr = 1'b0; addr_at = '0; wd_at = '0;
      do begin
         cyc();
         lat++;
         if (MEM_READ) begin saw_rd = 1'b1; addr_at = MEM_ADDRESS; end
         if (MEM_WRITE) begin saw_wr = 1'b1; addr_at = MEM_ADDRESS; wd_at = MEM_WRITE_DATA; end
         busy = (side == 1) ? INS_BUSY_WAIT : DATA_BUSY_WAIT;
      end while (busy && lat < 40);
      if (busy) chk("serve_timeout", LW'(lat), LW'(0));
   endtask

   int            lat;
   bit            s_rd, s_wr;
   logic [AW-1:0] s_addr;
   logic [LW-1:0] s_wd;
   logic [LW-1:0] line_a, line_b, line_c;

   initial begin
      RESET = 1'b0;
      drop_all();
      INS_ADDRESS = '0; DATA_ADDRESS = '0; DATA_WRITE_DATA = '0;
      MEM_READ_DATA = '0; MEM_BUSY_WAIT = 1'b0;
      #1;
      RESET = 1'b1;
      check_en = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();

      // reset state
      @(negedge CLK);
      chk("rst_mem_read", LW'(MEM_READ), LW'(0));
      chk("rst_mem_write", LW'(MEM_WRITE), LW'(0));
      chk("rst_mem_addr", LW'(MEM_ADDRESS), LW'(0));
      chk("rst_ins_rdata", INS_READ_DATA, LW'(0));
      chk("rst_data_rdata", DATA_READ_DATA, LW'(0));

      // I-only read, memory busy 5 cycles
      line_a = 128'h0123456789ABCDEF0123456789ABCDEF;
      tick();
      mem_n = 5; MEM_READ_DATA = line_a;
      INS_ADDRESS = 28'h0000004; INS_READ = 1'b1;
      serve(1, lat, s_rd, s_wr, s_addr, s_wd);
      chk("i_read_lat", LW'(lat), LW'(8));
      chk("i_read_seen", LW'({s_rd, s_wr}), LW'(2'b10));
      chk("i_read_addr", LW'(s_addr), LW'(28'h0000004));
      chk("i_read_data", INS_READ_DATA, line_a);
      cyc();
      chk("i_busy_one_cycle", LW'(INS_BUSY_WAIT), LW'(1));
      tick();
      settle();

      // D write-back
      do_reset();
      mem_n = 2; MEM_READ_DATA = rnd128();
      DATA_ADDRESS = 28'h0000010; DATA_WRITE_DATA = {4{32'hAAAAAAAA}}; DATA_WRITE = 1'b1;
      serve(2, lat, s_rd, s_wr, s_addr, s_wd);
      chk("d_write_lat", LW'(lat), LW'(5));
      chk("d_write_seen", LW'({s_rd, s_wr}), LW'(2'b01));
      chk("d_write_addr", LW'(s_addr), LW'(28'h0000010));
      chk("d_write_wdata", s_wd, {4{32'hAAAAAAAA}});
      chk("d_write_rdata", DATA_READ_DATA, LW'(0));
      cyc();
      chk("d_busy_one_cycle", LW'(DATA_BUSY_WAIT), LW'(1));
      tick();
      settle();

      // simultaneous I and D reads, both held: I, then D, then I again
      do_reset();
      mem_n = 0; MEM_READ_DATA = rnd128();
      INS_ADDRESS = 28'h0000111; DATA_ADDRESS = 28'h0000222;
      INS_READ = 1'b1; DATA_READ = 1'b1;
      cyc();
      chk("tie1_addr", LW'(MEM_ADDRESS), LW'(28'h0000111));
      chk("tie1_read", LW'(MEM_READ), LW'(1));
      repeat (3) cyc();
      chk("tie_gap_idle", LW'(MEM_READ), LW'(0));
      cyc();
      chk("tie2_addr", LW'(MEM_ADDRESS), LW'(28'h0000222));
      chk("tie2_read", LW'(MEM_READ), LW'(1));
      repeat (4) cyc();
      chk("tie3_addr", LW'(MEM_ADDRESS), LW'(28'h0000111));
      tick();
      settle();

      // read and write both high: write only
      do_reset();
      mem_n = 1; MEM_READ_DATA = rnd128();
      DATA_ADDRESS = 28'h0000033; DATA_WRITE_DATA = rnd128();
      DATA_READ = 1'b1; DATA_WRITE = 1'b1;
      serve(2, lat, s_rd, s_wr, s_addr, s_wd);
      chk("rw_both_seen", LW'({s_rd, s_wr}), LW'(2'b01));
      chk("rw_both_rdata", DATA_READ_DATA, LW'(0));
      tick();
      settle();

      // reset pulsed in the third GNT_D cycle
      line_b = rnd128();
      line_c = rnd128();
      do_reset();
      mem_n = 3; MEM_READ_DATA = line_b;
      DATA_ADDRESS = 28'h0000030; DATA_READ = 1'b1;
      serve(2, lat, s_rd, s_wr, s_addr, s_wd);
      chk("pre_rst_rdata", DATA_READ_DATA, line_b);
      tick();
      settle();
      tick();
      MEM_READ_DATA = line_c; DATA_READ = 1'b1;
      repeat (3) cyc();
      #3;
      RESET = 1'b1;
      #1;
      chk("rst_abort_read", LW'({MEM_READ, MEM_WRITE}), LW'(0));
      chk("rst_abort_rdata", DATA_READ_DATA, LW'(0));
      tick();
      RESET = 1'b0;
      serve(2, lat, s_rd, s_wr, s_addr, s_wd);
      chk("rst_reserve_lat", LW'(lat), LW'(6));
      chk("rst_reserve_rdata", DATA_READ_DATA, line_c);
      tick();
      settle();

      // zero-wait memory
      do_reset();
      mem_n = 0; MEM_READ_DATA = rnd128();
      INS_ADDRESS = 28'h0ABCDEF; INS_READ = 1'b1;
      serve(1, lat, s_rd, s_wr, s_addr, s_wd);
      chk("zero_wait_lat", LW'(lat), LW'(3));
      tick();
      settle();

      // random traffic
      idle_busy_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (RESET) RESET = 1'b0;
         else if ($urandom_range(0, 499) == 0) RESET = 1'b1;
         if ($urandom_range(0, 3) == 0) INS_READ = ~INS_READ;
         if ($urandom_range(0, 3) == 0) DATA_READ = ~DATA_READ;
         if ($urandom_range(0, 5) == 0) DATA_WRITE = ~DATA_WRITE;
         INS_ADDRESS = AW'($urandom);
         DATA_ADDRESS = AW'($urandom);
         DATA_WRITE_DATA = rnd128();
         MEM_READ_DATA = rnd128();
         if ($urandom_range(0, 7) == 0) mem_n = $urandom_range(0, 4);
      end
      idle_busy_rand = 1'b0;
      settle();
      check_en = 1'b0;

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
